alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_shifter.sv | 39 +++
 rtl/alu_core.sv | 82 ++++++++
 tb/tb_alu_core.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared width constant and operation/shift encodings for alu_core
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_SHL  = 2'b01,
        SH_SHR  = 2'b10,
        SH_SAR  = 2'b11
    } shift_e;

    // Zero detect on the final, post-shift value; carry never participates.
    function automatic logic is_zero(input logic [ALU_W-1:0] value);
        return (value == '0);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - combinational post-op shifter; the shifted-out bit replaces the op carry
module alu_shifter
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] op,
    input  logic             c_op,
    input  logic [1:0]       shift,
    output logic [ALU_W-1:0] result,
    output logic             cout
);

    always_comb begin
        result = op;
        cout   = c_op;
        unique case (shift_e'(shift))
            SH_NONE: begin
                result = op;
                cout   = c_op;
            end
            SH_SHL: begin
                result = {op[ALU_W-2:0], 1'b0};
                cout   = op[ALU_W-1];
            end
            SH_SHR: begin
                result = {1'b0, op[ALU_W-1:1]};
                cout   = op[0];
            end
            SH_SAR: begin
                result = {op[ALU_W-1], op[ALU_W-1:1]};
                cout   = op[0];
            end
            default: begin
                result = op;
                cout   = c_op;
            end
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// rtl/alu_core.sv - 8-bit registered ALU (ADD/SUB/AND/OR) with optional post-op shifter under ALU_SHIFT_EN
module alu_core
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [1:0]       ALU_sel,
    input  logic [1:0]       load_shift,
    output logic [ALU_W-1:0] result,
    output logic             cout,
    output logic             zout
);

    logic [ALU_W:0]   sum_ext;
    logic [ALU_W:0]   diff_ext;
    logic [ALU_W-1:0] op;
    logic             c_op;
    logic [ALU_W-1:0] final_val;
    logic             final_c;

    // One extra bit captures carry on add and borrow (a < b) on subtract.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    always_comb begin
        op   = '0;
        c_op = 1'b0;
        unique case (alu_op_e'(ALU_sel))
            ALU_ADD: begin
                op   = sum_ext[ALU_W-1:0];
                c_op = sum_ext[ALU_W];
            end
            ALU_SUB: begin
                op   = diff_ext[ALU_W-1:0];
                c_op = diff_ext[ALU_W];
            end
            ALU_AND: begin
                op   = a & b;
                c_op = 1'b0;
            end
            ALU_OR: begin
                op   = a | b;
                c_op = 1'b0;
            end
            default: begin
                op   = '0;
                c_op = 1'b0;
            end
        endcase
    end

`ifdef ALU_SHIFT_EN
    alu_shifter u_shifter (
        .op     (op),
        .c_op   (c_op),
        .shift  (load_shift),
        .result (final_val),
        .cout   (final_c)
    );
`else
    // Shift select is accepted on the port but has no effect in this build.
    logic unused_load_shift;
    assign unused_load_shift = ^load_shift;
    assign final_val         = op;
    assign final_c           = c_op;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            cout   <= 1'b0;
            zout   <= 1'b0;
        end else begin
            result <= final_val;
            cout   <= final_c;
            zout   <= is_zero(final_val);
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - scoreboard bench for alu_core; expectations follow ALU_SHIFT_EN when defined
module tb_alu_core;

    logic       clk;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] ALU_sel;
    logic [1:0] load_shift;
    logic [7:0] result;
    logic       cout;
    logic       zout;

    int checks;
    int errors;

    logic [9:0] exp_q[$];
    string      tag_q[$];

    alu_core dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .ALU_sel    (ALU_sel),
        .load_shift (load_shift),
        .result     (result),
        .cout       (cout),
        .zout       (zout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %03h expected %03h", tag, got, exp);
        end
    endtask

    // Independent reference: integer arithmetic, returns {zout, cout, result}.
    function automatic logic [9:0] model(input logic [7:0] ta, input logic [7:0] tb,
                                         input logic [1:0] sel, input logic [1:0] sh,
                                         input logic rst);
        int         r;
        logic       c;
        logic [7:0] v;
        if (rst) return 10'h000;
        r = 0;
        c = 1'b0;
        case (sel)
            2'd0: begin r = int'(ta) + int'(tb); c = (r > 255); r = r % 256; end
            2'd1: begin c = (ta < tb); r = (int'(ta) - int'(tb) + 256) % 256; end
            2'd2: r = int'(ta & tb);
            default: r = int'(ta | tb);
        endcase
        v = r[7:0];
`ifdef ALU_SHIFT_EN
        case (sh)
            2'd1: begin c = v[7]; v = v << 1; end
            2'd2: begin c = v[0]; v = v >> 1; end
            2'd3: begin c = v[0]; v = (v >> 1) | (v & 8'h80); end
            default: ;
        endcase
`else
        if (sh == 2'd0) v = v;
`endif
        return {(v == 8'h00), c, v};
    endfunction

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] sel,
                        input logic [1:0] sh, input logic rst, input string tag);
        logic [9:0] exp;
        string      t;
        a          = ta;
        b          = tb;
        ALU_sel    = sel;
        load_shift = sh;
        reset      = rst;
        exp_q.push_back(model(ta, tb, sel, sh, rst));
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        t   = tag_q.pop_front();
        check(t, {zout, cout, result}, exp);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        a          = 8'h00;
        b          = 8'h00;
        ALU_sel    = 2'b00;
        load_shift = 2'b00;

        step(8'hFF, 8'h01, 2'b00, 2'b00, 1'b1, "reset_hold0");
        step(8'hFF, 8'h01, 2'b00, 2'b00, 1'b1, "reset_hold1");
        check("reset_const", {zout, cout, result}, 10'h000);

        step(8'hFF, 8'h01, 2'b00, 2'b00, 1'b0, "add_wrap");
        check("add_wrap_const", {zout, cout, result}, 10'h300);
        step(8'h05, 8'h07, 2'b01, 2'b00, 1'b0, "sub_borrow");
        check("sub_borrow_const", {zout, cout, result}, 10'h1FE);
        step(8'h07, 8'h07, 2'b01, 2'b00, 1'b0, "sub_zero");
        check("sub_zero_const", {zout, cout, result}, 10'h200);
        step(8'hF0, 8'h0F, 2'b10, 2'b00, 1'b0, "and_zero");
        check("and_zero_const", {zout, cout, result}, 10'h200);
        step(8'h81, 8'h00, 2'b11, 2'b01, 1'b0, "or_shl");
`ifdef ALU_SHIFT_EN
        check("or_shl_const", {zout, cout, result}, 10'h102);
`else
        check("or_shl_ignored", {zout, cout, result}, 10'h081);
`endif
        step(8'h40, 8'h40, 2'b00, 2'b10, 1'b0, "shr_carry");
        step(8'h81, 8'h00, 2'b11, 2'b11, 1'b0, "sar_carry");
`ifdef ALU_SHIFT_EN
        check("sar_carry_const", {zout, cout, result}, 10'h1C0);
`endif
        step(8'h12, 8'h34, 2'b00, 2'b00, 1'b0, "add_plain");
        step(8'h80, 8'h80, 2'b00, 2'b00, 1'b0, "add_carry_zero");
        step(8'h00, 8'h01, 2'b01, 2'b00, 1'b0, "sub_underflow");
        step(8'hAA, 8'h55, 2'b11, 2'b00, 1'b0, "or_ff");

        step(8'hFF, 8'hFF, 2'b00, 2'b00, 1'b1, "reset_mid");
        step(8'h01, 8'h02, 2'b00, 2'b00, 1'b0, "first_after_reset");
        check("first_after_reset_const", {zout, cout, result}, 10'h003);

        for (int i = 0; i < 40; i++) begin
            step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 15) == 0), "random");
        end

        if (exp_q.size() != 0) check("scoreboard_empty", 10'(exp_q.size()), 10'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
